// File: rtl/emulador_hcsr04.sv
// HC-SR04 ultrasonic sensor emulator: answers a trigger pulse with an
// echo pulse whose width encodes the programmed distance.
module emulador_hcsr04 #(
  parameter int CICLOS_TRIGGER_MIN = 500,
  parameter int CICLOS_ATRASO      = 20000,
  parameter int CICLOS_POR_CM      = 2941,
  parameter int DISTANCIA_MAX      = 400,
  parameter int CICLOS_TIMEOUT     = 1900000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       pronto,
  output logic       ocupado,
  output logic [3:0] db_estado
);

  localparam logic [9:0]  TRIG_MIN    = 10'(CICLOS_TRIGGER_MIN);
  localparam logic [14:0] ATRASO_FIM  = 15'(CICLOS_ATRASO - 1);
  localparam logic [11:0] SUB_FIM     = 12'(CICLOS_POR_CM - 1);
  localparam logic [8:0]  DIST_MAX    = 9'(DISTANCIA_MAX);
  localparam logic [20:0] TIMEOUT_FIM = 21'(CICLOS_TIMEOUT - 1);

  typedef enum logic [3:0] {
    OCIOSO       = 4'd0,
    MEDE_TRIGGER = 4'd1,
    ATRASO       = 4'd2,
    ECO          = 4'd3,
    FIM          = 4'd4
  } estado_t;

  estado_t     estado, estado_d;
  logic        trig_m, trig_s;
  logic        armado, armado_d;
  logic [9:0]  cnt_larg, cnt_larg_d;
  logic [14:0] cnt_atraso, cnt_atraso_d;
  logic [11:0] cnt_sub, cnt_sub_d;
  logic [8:0]  cnt_cm, cnt_cm_d;
  logic [20:0] cnt_to, cnt_to_d;
  logic [8:0]  dist_r, dist_r_d;
  logic        dist_valida;

  assign dist_valida = (dist_r != 9'd0) && (dist_r <= DIST_MAX);
  assign db_estado   = estado;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      trig_m     <= 1'b0;
      trig_s     <= 1'b0;
      estado     <= OCIOSO;
      armado     <= 1'b0;
      cnt_larg   <= '0;
      cnt_atraso <= '0;
      cnt_sub    <= '0;
      cnt_cm     <= '0;
      cnt_to     <= '0;
      dist_r     <= '0;
      echo       <= 1'b0;
      pronto     <= 1'b0;
      ocupado    <= 1'b0;
    end else begin
      trig_m     <= trigger;
      trig_s     <= trig_m;
      estado     <= estado_d;
      armado     <= armado_d;
      cnt_larg   <= cnt_larg_d;
      cnt_atraso <= cnt_atraso_d;
      cnt_sub    <= cnt_sub_d;
      cnt_cm     <= cnt_cm_d;
      cnt_to     <= cnt_to_d;
      dist_r     <= dist_r_d;
      echo       <= (estado_d == ECO);
      pronto     <= (estado_d == FIM);
      ocupado    <= (estado_d != OCIOSO);
    end
  end

  always_comb begin
    estado_d     = estado;
    armado_d     = armado;
    cnt_larg_d   = cnt_larg;
    cnt_atraso_d = cnt_atraso;
    cnt_sub_d    = cnt_sub;
    cnt_cm_d     = cnt_cm;
    cnt_to_d     = cnt_to;
    dist_r_d     = dist_r;
    unique case (estado)
      OCIOSO: begin
        if (!trig_s) begin
          armado_d = 1'b1;
        end else if (armado) begin
          // the high cycle that starts the measurement counts toward width
          cnt_larg_d = 10'd1;
          armado_d   = 1'b0;
          estado_d   = MEDE_TRIGGER;
        end
      end
      MEDE_TRIGGER: begin
        if (trig_s) begin
          if (cnt_larg < TRIG_MIN) cnt_larg_d = cnt_larg + 10'd1;
        end else if (cnt_larg >= TRIG_MIN) begin
          dist_r_d     = distancia;
          cnt_atraso_d = '0;
          estado_d     = ATRASO;
        end else begin
          estado_d = OCIOSO;
        end
      end
      ATRASO: begin
        if (cnt_atraso == ATRASO_FIM) begin
          cnt_sub_d = '0;
          cnt_cm_d  = '0;
          cnt_to_d  = '0;
          estado_d  = ECO;
        end else begin
          cnt_atraso_d = cnt_atraso + 15'd1;
        end
      end
      ECO: begin
        if (dist_valida) begin
          if (cnt_sub == SUB_FIM) begin
            cnt_sub_d = '0;
            cnt_cm_d  = cnt_cm + 9'd1;
            if (cnt_cm + 9'd1 == dist_r) estado_d = FIM;
          end else begin
            cnt_sub_d = cnt_sub + 12'd1;
          end
        end else if (cnt_to == TIMEOUT_FIM) begin
          estado_d = FIM;
        end else begin
          cnt_to_d = cnt_to + 21'd1;
        end
      end
      FIM: begin
        armado_d = 1'b0;
        estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

endmodule
